// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit:
// FSM encoding, instruction word size and the IF/ID reset value.
package instr_fetch_unit_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    END   = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP         = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit, the combinational instruction memory and decode.
// Handshake: the IF/ID entry transfers on a rising edge where id_valid_o=1 and id_ready_i=1.
// id_valid_o never depends combinationally on id_ready_i, and the entry is held while it waits.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic [31:0]  addr_o;
  logic [31:0]  instr_i;
  logic         redirect_i;
  logic [31:0]  target_i;
  logic         id_valid_o;
  logic         id_ready_i;
  logic [31:0]  id_instr_o;
  logic [31:0]  id_pc4_o;
  logic         done_o;
  logic         misalign_o;
  fetch_state_t state_o;

  modport master (
    output addr_o, id_valid_o, id_instr_o, id_pc4_o, done_o, misalign_o, state_o,
    input  instr_i, redirect_i, target_i, id_ready_i
  );

  modport slave (
    input  addr_o, id_valid_o, id_instr_o, id_pc4_o, done_o, misalign_o, state_o,
    output instr_i, redirect_i, target_i, id_ready_i
  );

endinterface

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: one instruction plus its PC+4, valid/ready drained,
// with a flush that kills the entry regardless of ready.
module instr_fetch_unit_if_id_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        capture,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] new_instr,
  input  logic [31:0] new_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  // Data only moves on capture, so a stalled or flushed entry keeps its contents.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= 1'b0;
      instr <= NOP;
      pc4   <= NOP;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      instr <= new_instr;
      pc4   <= new_pc4;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, FETCH/END state machine, branch redirect and
// the IF/ID register feeding decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned INSTR_COUNT = 21
) (
  input  logic               clk_i,
  input  logic               rst_i,
  instr_fetch_unit_if.master bus
);

  localparam logic [31:0] PC_LIMIT = 32'(INSTR_COUNT) * INSTR_BYTES;

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4, redirect_pc;
  logic         misalign, misalign_next;
  logic         adv, capture;
  logic         id_valid;
  logic [31:0]  id_instr, id_pc4;

  assign pc_plus4    = pc + INSTR_BYTES;
  assign redirect_pc = {bus.target_i[31:2], 2'b00};
  assign adv         = (state == FETCH) && (!id_valid || bus.id_ready_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= FETCH;
      pc       <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      misalign <= misalign_next;
    end
  end

  // Redirect beats the sequential fetch in every state; the range compare is unsigned.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    misalign_next = misalign;
    capture       = 1'b0;
    if (bus.redirect_i) begin
      pc_next    = redirect_pc;
      state_next = (redirect_pc < PC_LIMIT) ? FETCH : END;
      if (bus.target_i[1:0] != 2'b00) begin
        misalign_next = 1'b1;
      end
    end else if (adv) begin
      capture    = 1'b1;
      pc_next    = pc_plus4;
      state_next = (pc_plus4 >= PC_LIMIT) ? END : FETCH;
    end
  end

  instr_fetch_unit_if_id_reg u_if_id (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .capture   (capture),
    .flush     (bus.redirect_i),
    .ready     (bus.id_ready_i),
    .new_instr (bus.instr_i),
    .new_pc4   (pc_plus4),
    .valid     (id_valid),
    .instr     (id_instr),
    .pc4       (id_pc4)
  );

  assign bus.addr_o     = pc;
  assign bus.id_valid_o = id_valid;
  assign bus.id_instr_o = id_instr;
  assign bus.id_pc4_o   = id_pc4;
  assign bus.done_o     = (state == END);
  assign bus.misalign_o = misalign;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of per-cycle stimulus with expected
// post-edge outputs, plus hand sequences for reset behaviour.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(.INSTR_COUNT(21)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (ifc)
  );

  // Instruction memory model: word k holds value k.
  assign ifc.instr_i = ifc.addr_o >> 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redirect;
    logic [31:0] target;
    logic        ready;
    logic [31:0] addr;
    logic        valid;
    logic        chk_data;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        done;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rd, input logic [31:0] tg, input logic rdy,
                              input logic [31:0] a, input logic v, input logic cd,
                              input logic [31:0] i, input logic [31:0] p,
                              input logic d, input logic m);
    vec_t x;
    x.redirect = rd; x.target = tg; x.ready = rdy;
    x.addr = a; x.valid = v; x.chk_data = cd; x.instr = i; x.pc4 = p;
    x.done = d; x.mis = m;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  ifc.addr_o, 32'd0);
    chk({tag, "_valid"}, 32'(ifc.id_valid_o), 32'd0);
    chk({tag, "_instr"}, ifc.id_instr_o, 32'd0);
    chk({tag, "_pc4"},   ifc.id_pc4_o, 32'd0);
    chk({tag, "_done"},  32'(ifc.done_o), 32'd0);
    chk({tag, "_mis"},   32'(ifc.misalign_o), 32'd0);
    chk({tag, "_state"}, 32'(ifc.state_o), 32'(FETCH));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b1;
    ifc.redirect_i = 1'b0;
    ifc.target_i   = '0;
    ifc.id_ready_i = 1'b0;

    //  rd tgt   rdy addr v  cd instr pc4 done mis
    add(0, 0,    1,  4,   1, 1, 0,  4,  0, 0);   // first capture
    add(0, 0,    0,  4,   1, 1, 0,  4,  0, 0);   // 3-cycle stall
    add(0, 0,    0,  4,   1, 1, 0,  4,  0, 0);
    add(0, 0,    0,  4,   1, 1, 0,  4,  0, 0);
    add(0, 0,    1,  8,   1, 1, 1,  8,  0, 0);   // resume, no loss
    add(0, 0,    1,  12,  1, 1, 2,  12, 0, 0);   // word 2 in IF/ID
    add(1, 32,   0,  32,  0, 0, 0,  0,  0, 0);   // redirect flushes despite not ready
    add(0, 0,    0,  36,  1, 1, 8,  36, 0, 0);
    add(0, 0,    1,  40,  1, 1, 9,  40, 0, 0);
    for (int k = 10; k <= 20; k++)
      add(0, 0, 1, 32'(4*k+4), 1, 1, 32'(k), 32'(4*k+4), (k == 20), 0);
    add(0, 0,    1,  84,  0, 0, 0,  0,  1, 0);   // END: drain, no more fetches
    add(0, 0,    1,  84,  0, 0, 0,  0,  1, 0);
    add(1, 12,   1,  12,  0, 0, 0,  0,  0, 0);   // restart from END
    add(0, 0,    1,  16,  1, 1, 3,  16, 0, 0);
    add(1, 32'h13, 1, 16, 0, 0, 0,  0,  0, 1);   // misaligned redirect
    add(0, 0,    1,  20,  1, 1, 4,  20, 0, 1);
    add(0, 0,    0,  20,  1, 1, 4,  20, 0, 1);
    add(1, 200,  0,  200, 0, 0, 0,  0,  1, 1);   // out-of-range redirect
    add(0, 0,    1,  200, 0, 0, 0,  0,  1, 1);
    add(1, 80,   1,  80,  0, 0, 0,  0,  0, 1);   // last in-range word
    add(0, 0,    0,  84,  1, 1, 20, 84, 1, 1);
    add(0, 0,    0,  84,  1, 1, 20, 84, 1, 1);   // END holds pending entry
    add(0, 0,    1,  84,  0, 0, 0,  0,  1, 1);

    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      ifc.redirect_i = vecs[i].redirect;
      ifc.target_i   = vecs[i].target;
      ifc.id_ready_i = vecs[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_addr", i),  ifc.addr_o, vecs[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(ifc.id_valid_o), 32'(vecs[i].valid));
      chk($sformatf("v%0d_done", i),  32'(ifc.done_o), 32'(vecs[i].done));
      chk($sformatf("v%0d_mis", i),   32'(ifc.misalign_o), 32'(vecs[i].mis));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_instr", i), ifc.id_instr_o, vecs[i].instr);
        chk($sformatf("v%0d_pc4", i),   ifc.id_pc4_o, vecs[i].pc4);
      end
    end

    // Reset asserted mid-stall with a valid entry, away from the clock edge.
    ifc.redirect_i = 1'b1;
    ifc.target_i   = 32'd8;
    ifc.id_ready_i = 1'b0;
    @(posedge clk);
    #1;
    ifc.redirect_i = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("stall_valid", 32'(ifc.id_valid_o), 32'd1);
    chk("stall_instr", ifc.id_instr_o, 32'd2);
    chk("stall_addr",  ifc.addr_o, 32'd12);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    ifc.id_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_addr",  ifc.addr_o, 32'd4);
    chk("restart_valid", 32'(ifc.id_valid_o), 32'd1);
    chk("restart_instr", ifc.id_instr_o, 32'd0);
    chk("restart_pc4",   ifc.id_pc4_o, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
